gf180mcu_pwr_wake_seq: RTL and testbench

Staggered power-switch wake/sleep sequencer for a gated VDD domain built from the mcu9t5v0 library. Fillcap cells supply charge on the rail; this block manages the load side by turning on header-switch segments one at a time so inrush stays within what the fillcap bank can absorb. It waits for a supply-good indication and flags a fault on timeout or collapse. It sits in the always-on domain between the power controller (requests) and the switch segments (enables).

---
 rtl/gf180mcu_pwr_seq_pkg.sv | 14 +
 rtl/gf180mcu_pwr_seg_therm.sv | 18 +
 rtl/gf180mcu_pwr_wake_seq.sv | 94 +++++++++
 tb/tb_gf180mcu_pwr_wake_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_pwr_seq_pkg.sv
// gf180mcu_pwr_seq_pkg: shared state encoding and parameter legality for the wake sequencer
package gf180mcu_pwr_seq_pkg;
   typedef enum logic [5:0] {
      S_OFF       = 6'b000001,
      S_RAMP_UP   = 6'b000010,
      S_WAIT_GOOD = 6'b000100,
      S_ON        = 6'b001000,
      S_RAMP_DOWN = 6'b010000,
      S_FAULT     = 6'b100000
   } seq_state_t;
   function automatic bit params_ok(input int nseg, input int step_cyc, input int good_timeout);
      return (nseg >= 2) && (step_cyc >= 1) && (good_timeout >= 1);
   endfunction
endpackage

// File: rtl/gf180mcu_pwr_seg_therm.sv
// gf180mcu_pwr_seg_therm: up/down thermometer shift register driving header-switch segments
module gf180mcu_pwr_seg_therm #(
   parameter int NSEG = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_shift_up,
   input  logic            i_shift_down,
   input  logic            i_clear,
   output logic [NSEG-1:0] o_therm
);
   logic [NSEG-1:0] r_therm;
   always_ff @(posedge i_clk)
      if (i_rst || i_clear) r_therm <= '0;
      else if (i_shift_up) r_therm <= {r_therm[NSEG-2:0], 1'b1};
      else if (i_shift_down) r_therm <= {1'b0, r_therm[NSEG-1:1]};
   assign o_therm = r_therm;
endmodule

// File: rtl/gf180mcu_pwr_wake_seq.sv
// gf180mcu_pwr_wake_seq: staggered header-switch wake/sleep sequencer with supply-good timeout
module gf180mcu_pwr_wake_seq
   import gf180mcu_pwr_seq_pkg::*;
#(
   parameter int NSEG         = 8,
   parameter int STEP_CYC     = 4,
   parameter int GOOD_TIMEOUT = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_on,
   input  logic            i_req_off,
   input  logic            i_pwr_good,
   output logic [NSEG-1:0] o_seg_en,
   output logic            o_ready,
   output logic            o_busy,
   output logic            o_fault
);
   localparam int STEP_W = $clog2(STEP_CYC + 1);
   localparam int TOUT_W = $clog2(GOOD_TIMEOUT + 1);
   if (!params_ok(NSEG, STEP_CYC, GOOD_TIMEOUT)) begin : g_bad_params
      $error("gf180mcu_pwr_wake_seq: illegal parameters");
   end
   seq_state_t        r_state, w_next;
   logic [STEP_W-1:0] r_step;
   logic [TOUT_W-1:0] r_tout;
   logic [NSEG-1:0]   w_seg;
   logic              w_up, w_down, w_clear, w_term, w_tout_end, w_full;
   assign w_term     = r_step == STEP_W'(STEP_CYC - 1);
   assign w_tout_end = r_tout == TOUT_W'(GOOD_TIMEOUT - 1);
   assign w_full     = &w_seg;
   always_ff @(posedge i_clk) begin
      r_state <= i_rst ? S_OFF : w_next;
      if (i_rst || w_next != r_state) r_step <= '0;
      else r_step <= (r_state inside {S_RAMP_UP, S_RAMP_DOWN}) && !w_term ? r_step + STEP_W'(1) : '0;
      if (i_rst || r_state != S_WAIT_GOOD || w_next != r_state) r_tout <= '0;
      else if (!w_tout_end) r_tout <= r_tout + TOUT_W'(1);
   end
   always_comb begin
      w_next  = r_state;
      w_up    = 1'b0;
      w_down  = 1'b0;
      w_clear = 1'b0;
      case (r_state)
         S_OFF: if (i_req_on && !i_req_off) begin
            w_next = S_RAMP_UP;
            w_up   = 1'b1;
         end
         S_RAMP_UP:
            if (i_req_off) w_next = S_RAMP_DOWN;
            else if (w_term) begin
               if (w_full) w_next = S_WAIT_GOOD;
               else w_up = 1'b1;
            end
         S_WAIT_GOOD:
            if (i_req_off) w_next = S_RAMP_DOWN;
            else if (i_pwr_good) w_next = S_ON;
            else if (w_tout_end) begin
               w_next  = S_FAULT;
               w_clear = 1'b1;
            end
         S_ON:
            if (i_req_off) w_next = S_RAMP_DOWN;
            else if (!i_pwr_good) begin
               w_next  = S_FAULT;
               w_clear = 1'b1;
            end
         S_RAMP_DOWN:
            // the edge that clears bit 0 also lands in OFF
            if (!w_seg[0]) w_next = S_OFF;
            else if (w_term) begin
               w_down = 1'b1;
               if (!w_seg[1]) w_next = S_OFF;
            end
         S_FAULT: if (i_req_off) w_next = S_OFF;
         default: begin
            w_next  = S_OFF;
            w_clear = 1'b1;
         end
      endcase
   end
   gf180mcu_pwr_seg_therm #(.NSEG(NSEG)) u_therm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_shift_up   (w_up),
      .i_shift_down (w_down),
      .i_clear      (w_clear),
      .o_therm      (w_seg)
   );
   assign o_seg_en = w_seg;
   assign o_ready  = r_state == S_ON;
   assign o_busy   = r_state inside {S_RAMP_UP, S_WAIT_GOOD, S_RAMP_DOWN};
   assign o_fault  = r_state == S_FAULT;
endmodule

// File: tb/tb_gf180mcu_pwr_wake_seq.sv
// tb_gf180mcu_pwr_wake_seq: directed checks of ramp timing, timeout, fault and reset behaviour
module tb_gf180mcu_pwr_wake_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_on = 1'b0, req_off = 1'b0, pwr_good = 1'b0;
   logic [7:0] seg_en, seg_en_f;
   logic       ready, busy, fault, ready_f, busy_f, fault_f;
   int         n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   gf180mcu_pwr_wake_seq dut (
      .i_clk(clk), .i_rst(rst), .i_req_on(req_on), .i_req_off(req_off), .i_pwr_good(pwr_good),
      .o_seg_en(seg_en), .o_ready(ready), .o_busy(busy), .o_fault(fault)
   );

   gf180mcu_pwr_wake_seq #(.STEP_CYC(1)) dut_fast (
      .i_clk(clk), .i_rst(rst), .i_req_on(req_on), .i_req_off(req_off), .i_pwr_good(pwr_good),
      .o_seg_en(seg_en_f), .o_ready(ready_f), .o_busy(busy_f), .o_fault(fault_f)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ramp_to_wait;
      req_on = 1'b1;
      ticks(1);
      req_on = 1'b0;
      ticks(32);
   endtask

   initial begin
      // reset
      ticks(2);
      check("rst_seg", seg_en, 8'h00);
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault, 0);
      rst = 1'b0;
      ticks(1);
      // power-up with good arriving 5 cycles into WAIT_GOOD
      req_on = 1'b1;
      ticks(1);
      req_on = 1'b0;
      check("up_T_seg", seg_en, 8'h01);
      check("up_T_busy", busy, 1);
      check("fast_T_seg", seg_en_f, 8'h01);
      for (int i = 1; i <= 28; i++) begin
         ticks(1);
         if (i <= 7) check($sformatf("fast_T%0d_seg", i), seg_en_f, (32'd1 << (i + 1)) - 1);
         if (i == 3) check("up_T3_seg", seg_en, 8'h01);
         if (i == 4) check("up_T4_seg", seg_en, 8'h03);
         if (i == 27) check("up_T27_seg", seg_en, 8'h7F);
         if (i == 28) check("up_T28_seg", seg_en, 8'hFF);
      end
      check("fast_done_busy", busy_f, 1);
      ticks(4);
      check("wait_T32_busy", busy, 1);
      check("wait_T32_ready", ready, 0);
      ticks(5);
      check("wait_T37_ready", ready, 0);
      pwr_good = 1'b1;
      ticks(1);
      check("on_T38_ready", ready, 1);
      check("on_T38_busy", busy, 0);
      check("on_T38_seg", seg_en, 8'hFF);
      // orderly power-down from ON
      req_off = 1'b1;
      ticks(1);
      req_off = 1'b0;
      check("dn_R_ready", ready, 0);
      check("dn_R_busy", busy, 1);
      ticks(3);
      check("dn_R3_seg", seg_en, 8'hFF);
      ticks(1);
      check("dn_R4_seg", seg_en, 8'h7F);
      ticks(27);
      check("dn_R31_seg", seg_en, 8'h01);
      check("dn_R31_busy", busy, 1);
      ticks(1);
      check("dn_R32_seg", seg_en, 8'h00);
      check("dn_R32_busy", busy, 0);
      // good timeout
      pwr_good = 1'b0;
      ramp_to_wait;
      check("to_W_busy", busy, 1);
      req_on = 1'b1;
      ticks(63);
      check("to_W63_fault", fault, 0);
      check("to_W63_seg", seg_en, 8'hFF);
      ticks(1);
      check("to_W64_fault", fault, 1);
      check("to_W64_seg", seg_en, 8'h00);
      check("to_W64_busy", busy, 0);
      ticks(3);
      check("to_hold_fault", fault, 1);
      check("to_hold_seg", seg_en, 8'h00);
      req_on = 1'b0;
      req_off = 1'b1;
      ticks(1);
      req_off = 1'b0;
      check("to_clr_fault", fault, 0);
      check("to_clr_busy", busy, 0);
      // abort mid-ramp at 0x07
      req_on = 1'b1;
      ticks(1);
      req_on = 1'b0;
      ticks(8);
      check("ab_T8_seg", seg_en, 8'h07);
      req_off = 1'b1;
      ticks(1);
      req_off = 1'b0;
      check("ab_T9_busy", busy, 1);
      ticks(3);
      check("ab_T12_seg", seg_en, 8'h07);
      ticks(1);
      check("ab_T13_seg", seg_en, 8'h03);
      ticks(4);
      check("ab_T17_seg", seg_en, 8'h01);
      ticks(4);
      check("ab_T21_seg", seg_en, 8'h00);
      check("ab_T21_busy", busy, 0);
      // supply collapse while ON
      pwr_good = 1'b1;
      ramp_to_wait;
      ticks(1);
      check("col_on_ready", ready, 1);
      pwr_good = 1'b0;
      ticks(1);
      check("col_fault", fault, 1);
      check("col_seg", seg_en, 8'h00);
      check("col_ready", ready, 0);
      req_off = 1'b1;
      ticks(1);
      req_off = 1'b0;
      check("col_clr_fault", fault, 0);
      // REQ_OFF wins over simultaneous collapse
      pwr_good = 1'b1;
      ramp_to_wait;
      ticks(1);
      check("pri_on_ready", ready, 1);
      pwr_good = 1'b0;
      req_off = 1'b1;
      ticks(1);
      req_off = 1'b0;
      check("pri_fault", fault, 0);
      check("pri_busy", busy, 1);
      check("pri_seg", seg_en, 8'hFF);
      ticks(32);
      check("pri_end_seg", seg_en, 8'h00);
      check("pri_end_busy", busy, 0);
      // synchronous reset mid-ramp
      req_on = 1'b1;
      ticks(1);
      req_on = 1'b0;
      ticks(16);
      check("rs_seg_pre", seg_en, 8'h1F);
      rst = 1'b1;
      ticks(1);
      rst = 1'b0;
      check("rs_seg", seg_en, 8'h00);
      check("rs_busy", busy, 0);
      check("rs_ready", ready, 0);
      check("rs_fault", fault, 0);
      ticks(1);
      check("rs_stay_busy", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
